// File: rtl/rv_mem_pkg.sv
// Shared types for the rv_mem_resp memory responder.
// State encoding and the core's memrw encoding.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/rv_mem_array.sv
// Word-wide storage: synchronous write, combinational read.
// Not reset; contents survive rst.
module rv_mem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rv_mem_resp.sv
// Memory-side responder: one request at a time, LATENCY wait
// states, then a one-cycle ready pulse with registered outputs.
module rv_mem_resp
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        memrw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LAT_M1 =
    (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wd_q, wd_d;
  logic              mis_q, mis_d;

  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic        enter_resp;
  logic        mem_we;
  logic [31:0] mem_rd;
  logic        unused_hi;

  assign unused_hi = ^addr[31:ADDR_W+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    mis_d   = mis_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          rw_d  = memrw;
          idx_d = addr[ADDR_W+1:2];
          wd_d  = wdata;
          mis_d = (addr[1:0] != 2'b00);
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The _d request fields hold the live request on the
  // commit edge, which covers LATENCY=0 acceptance too.
  always_comb begin
    enter_resp = (state_d == RESP) && (state_q != RESP);
    mem_we     = enter_resp && !rst && !mis_d &&
                 (rw_d == MEM_WRITE);
    ready_d    = enter_resp;
    err_d      = enter_resp && mis_d;
    busy_d     = (state_d != IDLE);
    rdata_d    = '0;
    if (enter_resp && !mis_d && (rw_d == MEM_READ)) begin
      rdata_d = mem_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      idx_q   <= '0;
      wd_q    <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  rv_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (idx_d),
    .wdata_i (wd_d),
    .raddr_i (idx_d),
    .rdata_o (mem_rd)
  );

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_rv_mem_resp.sv
// Bench for rv_mem_resp: LATENCY=2 and LATENCY=0 instances,
// vector table, corner sequences and a random model check.
module tb_rv_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req2 = 1'b0;
  logic        req0 = 1'b0;
  logic        memrw = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rdata2, rdata0;
  logic        ready2, ready0;
  logic        err2, err0;
  logic        busy2, busy0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rv_mem_resp #(.ADDR_W(10), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .memrw(memrw),
    .addr(addr), .wdata(wdata), .rdata(rdata2),
    .ready(ready2), .err(err2), .busy(busy2)
  );

  rv_mem_resp #(.ADDR_W(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .memrw(memrw),
    .addr(addr), .wdata(wdata), .rdata(rdata0),
    .ready(ready0), .err(err0), .busy(busy0)
  );

  typedef struct {
    bit          rw;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] er;
    bit          ee;
  } vec_t;

  vec_t tv [8];
  logic [31:0] model [16];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic txn(input bit z, input bit rw,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     output logic [31:0] rd,
                     output bit e,
                     output int cyc);
    rd = '0;
    e = 1'b0;
    cyc = -1;
    @(negedge clk);
    memrw = rw;
    addr = a;
    wdata = d;
    req0 = z;
    req2 = !z;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    req2 = 1'b0;
    chk("busy_acc", {31'b0, z ? busy0 : busy2}, 32'h1);
    for (int k = 0; k < 20; k++) begin
      if (z ? ready0 : ready2) begin
        cyc = k + 1;
        rd = z ? rdata0 : rdata2;
        e = z ? err0 : err2;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("post_ctl", z ? {29'b0, ready0, busy0, err0}
                      : {29'b0, ready2, busy2, err2}, 32'h0);
    chk("post_rdata", z ? rdata0 : rdata2, 32'h0);
  endtask

  task automatic ctxn(input bit z, input bit rw,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [31:0] er,
                      input bit ee);
    logic [31:0] rd;
    bit e;
    int cyc;
    txn(z, rw, a, d, rd, e, cyc);
    chk("latency", 32'(cyc), z ? 32'd1 : 32'd3);
    chk("rdata", rd, er);
    chk("err", {31'b0, e}, {31'b0, ee});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit prev;
    logic [31:0] a, d, er;
    bit rw, ee;
    int idx;

    tv[0] = '{1'b1, 32'h10,   32'hDEADBEEF, 32'h0, 1'b0};
    tv[1] = '{1'b0, 32'h10,   32'h0, 32'hDEADBEEF, 1'b0};
    tv[2] = '{1'b1, 32'h20,   32'h11112222, 32'h0, 1'b0};
    tv[3] = '{1'b1, 32'h22,   32'h00001234, 32'h0, 1'b1};
    tv[4] = '{1'b0, 32'h20,   32'h0, 32'h11112222, 1'b0};
    tv[5] = '{1'b1, 32'h1004, 32'hA5A5A5A5, 32'h0, 1'b0};
    tv[6] = '{1'b0, 32'h4,    32'h0, 32'hA5A5A5A5, 1'b0};
    tv[7] = '{1'b0, 32'h11,   32'h0, 32'h0, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("idle2", {ready2, busy2, err2, rdata2[28:0]}, 32'h0);
      chk("idle0", {ready0, busy0, err0, rdata0[28:0]}, 32'h0);
      chk("idle_rd", rdata2 | rdata0, 32'h0);
    end

    for (int i = 0; i < 8; i++) begin
      ctxn(1'b0, tv[i].rw, tv[i].a, tv[i].d, tv[i].er, tv[i].ee);
    end

    // LATENCY=0: preload word 0, then hold req high.
    ctxn(1'b1, 1'b1, 32'h0, 32'h13, 32'h0, 1'b0);
    ctxn(1'b1, 1'b0, 32'h0, 32'h0, 32'h13, 1'b0);
    @(negedge clk);
    memrw = 1'b0;
    addr = 32'h0;
    req0 = 1'b1;
    cnt = 0;
    prev = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("hold_pat", {31'b0, ready0}, (k % 2 == 0) ? 1 : 0);
      if (ready0) begin
        cnt++;
        chk("hold_rd", rdata0, 32'h13);
      end
      prev = ready0;
    end
    req0 = 1'b0;
    chk("hold_cnt", 32'(cnt), 32'd5);

    // Request pulsed while busy must be dropped.
    @(negedge clk);
    memrw = 1'b1;
    addr = 32'h30;
    wdata = 32'h77;
    req2 = 1'b1;
    @(posedge clk);
    #1;
    req2 = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req2 = (k == 0);
      wdata = 32'hBAD;
      @(posedge clk);
      #1;
      req2 = 1'b0;
      if (ready2) cnt++;
    end
    chk("busy_drop", 32'(cnt), 32'd1);
    ctxn(1'b0, 1'b0, 32'h30, 32'h0, 32'h77, 1'b0);

    // Reset in WAIT, then reset on the commit edge.
    ctxn(1'b0, 1'b1, 32'h8, 32'h55, 32'h0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      memrw = 1'b1;
      addr = 32'h8;
      wdata = 32'hFFFFFFFF;
      req2 = 1'b1;
      @(posedge clk);
      #1;
      req2 = 1'b0;
      if (r == 1) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ctl", {30'b0, ready2, busy2}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
        if (ready2 || busy2) cnt++;
      end
      chk("rst_quiet", 32'(cnt), 32'd0);
      ctxn(1'b0, 1'b0, 32'h8, 32'h0, 32'h55, 1'b0);
    end

    // Random traffic against a word-window model.
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      ctxn(1'b0, 1'b1, 32'(i * 4), model[i], 32'h0, 1'b0);
    end
    for (int n = 0; n < 150; n++) begin
      idx = $urandom_range(0, 15);
      a = ($urandom_range(0, 15) << 12) | (idx << 2);
      if ($urandom_range(0, 3) == 0) a = a | $urandom_range(1, 3);
      rw = $urandom_range(0, 1) == 1;
      d = $urandom;
      ee = (a % 4) != 0;
      er = 32'h0;
      if (!ee && !rw) er = model[idx];
      if (!ee && rw) model[idx] = d;
      ctxn(1'b0, rw, a, d, er, ee);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
